// File: rtl/mc_alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcode encodings, handshake FSM
// states and the mul/div opcode classifier.
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADDU  = 4'b0010;
  localparam logic [3:0] OP_SUBU  = 4'b0011;
  localparam logic [3:0] OP_SLT   = 4'b0100;
  localparam logic [3:0] OP_SLTU  = 4'b0101;
  localparam logic [3:0] OP_XOR   = 4'b0110;
  localparam logic [3:0] OP_NOR   = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_ADD   = 4'b1010;
  localparam logic [3:0] OP_SUB   = 4'b1011;
  localparam logic [3:0] OP_MULTU = 4'b1100;
  localparam logic [3:0] OP_DIVU  = 4'b1101;
  localparam logic [3:0] OP_MULT  = 4'b1110;
  localparam logic [3:0] OP_DIV   = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Mul/div opcodes occupy 11xx; bit 0 selects divide, bit 1 selects signed.
  function automatic logic is_muldiv(input logic [3:0] control);
    return control[3:2] == 2'b11;
  endfunction

endpackage

// File: rtl/mc_alu_iter.sv
// Iterative unsigned engine: shift-add multiplier and restoring divider sharing
// one accumulator pair {r_acc, r_q} and one iteration counter.
module mc_alu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_last,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_hi
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [CW-1:0]    r_cnt;
  logic             r_is_div;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_b;

  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_diff;

  // Multiply: r_acc is the running high half, r_q the multiplier shifting out
  // as product bits shift in. Divide: r_acc is the partial remainder, r_q the
  // dividend shifting out as quotient bits shift in.
  always_comb begin
    w_add    = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : '0);
    w_rem_sh = {r_acc, r_q[WIDTH-1]};
    w_diff   = w_rem_sh - {1'b0, r_b};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_acc    <= '0;
      r_q      <= '0;
      r_b      <= '0;
    end else if (i_start) begin
      r_cnt    <= CW'(WIDTH);
      r_is_div <= i_is_div;
      r_acc    <= '0;
      r_q      <= i_a;
      r_b      <= i_b;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
      if (r_is_div) begin
        // Top bit of the difference is the borrow: set means restore.
        if (!w_diff[WIDTH]) begin
          r_acc <= w_diff[WIDTH-1:0];
          r_q   <= {r_q[WIDTH-2:0], 1'b1};
        end else begin
          r_acc <= w_rem_sh[WIDTH-1:0];
          r_q   <= {r_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        r_acc <= w_add[WIDTH:1];
        r_q   <= {w_add[0], r_q[WIDTH-1:1]};
      end
    end
  end

  assign o_last = (r_cnt == CW'(1));
  assign o_lo   = r_q;
  assign o_hi   = r_acc;

endmodule

// File: rtl/mc_alu.sv
// Multi-cycle ALU: valid/ready handshake FSM, single-cycle datapath, sign
// handling around the unsigned mul/div engine, and flag generation.
module mc_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       control,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic             o,
  output logic             z,
  output logic             busy,
  output state_t           o_dbg_state
);

  // Handshake: an operation transfers on a rising edge where in_valid && in_ready;
  // a result transfers where out_valid && out_ready. Both may happen on the same
  // edge. Outputs hold steady while out_valid && !out_ready.

  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam int M = WIDTH - 1;

  state_t           r_state;
  logic [WIDTH-1:0] r_out1;
  logic [WIDTH-1:0] r_out2;
  logic             r_o;
  logic             r_z;
  logic             r_out_valid;
  logic             r_busy;
  logic             r_signed;
  logic             r_is_div;
  logic             r_neg_lo;
  logic             r_neg_hi;

  logic             w_accept;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_sc_res;
  logic             w_sc_o;
  logic             w_sa;
  logic             w_sb;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic             w_div0;
  logic             w_divov;
  logic             w_start;
  logic             w_iter_last;
  logic [WIDTH-1:0] w_eng_lo;
  logic [WIDTH-1:0] w_eng_hi;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_fix_lo;
  logic [WIDTH-1:0] w_fix_hi;
  logic             w_fix_o;

  assign in_ready    = (r_state == IDLE) || (r_out_valid && out_ready);
  assign w_accept    = in_valid && in_ready;
  assign out_valid   = r_out_valid;
  assign out1        = r_out1;
  assign out2        = r_out2;
  assign o           = r_o;
  assign z           = r_z;
  assign busy        = r_busy;
  assign o_dbg_state = r_state;

  always_comb begin
    w_sum    = {1'b0, in1} + {1'b0, in2};
    w_diff   = {1'b0, in1} - {1'b0, in2};
    w_sc_res = '0;
    w_sc_o   = 1'b0;
    case (control)
      OP_AND:  w_sc_res = in1 & in2;
      OP_OR:   w_sc_res = in1 | in2;
      OP_ADDU: begin w_sc_res = w_sum[M:0];  w_sc_o = w_sum[WIDTH];  end
      OP_SUBU: begin w_sc_res = w_diff[M:0]; w_sc_o = w_diff[WIDTH]; end
      OP_SLT:  w_sc_res = {{(WIDTH-1){1'b0}}, $signed(in1) < $signed(in2)};
      OP_SLTU: w_sc_res = {{(WIDTH-1){1'b0}}, in1 < in2};
      OP_XOR:  w_sc_res = in1 ^ in2;
      OP_NOR:  w_sc_res = ~(in1 | in2);
      OP_SLL:  w_sc_res = in2 << in1[SHW-1:0];
      OP_SRL:  w_sc_res = in2 >> in1[SHW-1:0];
      OP_ADD: begin
        w_sc_res = w_sum[M:0];
        w_sc_o   = (in1[M] == in2[M]) && (w_sum[M] != in1[M]);
      end
      OP_SUB: begin
        w_sc_res = w_diff[M:0];
        w_sc_o   = (in1[M] != in2[M]) && (w_diff[M] != in1[M]);
      end
      default: begin
        w_sc_res = '0;
        w_sc_o   = 1'b0;
      end
    endcase
  end

  // Engine sees magnitudes only; the most-negative value maps to itself, which
  // is its correct unsigned magnitude.
  always_comb begin
    w_sa    = control[1] & in1[M];
    w_sb    = control[1] & in2[M];
    w_mag_a = w_sa ? (~in1 + 1'b1) : in1;
    w_mag_b = w_sb ? (~in2 + 1'b1) : in2;
    w_div0  = control[0] && (in2 == '0);
    w_divov = (control == OP_DIV) && (in1 == MIN_NEG) && (in2 == '1);
    w_start = w_accept && is_muldiv(control) && !w_div0 && !w_divov;
  end

  mc_alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_start),
    .i_is_div (control[0]),
    .i_a      (w_mag_a),
    .i_b      (w_mag_b),
    .o_last   (w_iter_last),
    .o_lo     (w_eng_lo),
    .o_hi     (w_eng_hi)
  );

  // Product sign is applied across the full double-width value; quotient and
  // remainder are negated independently.
  always_comb begin
    w_prod   = {w_eng_hi, w_eng_lo};
    w_fix_lo = w_eng_lo;
    w_fix_hi = w_eng_hi;
    w_fix_o  = 1'b0;
    if (r_is_div) begin
      w_fix_lo = r_neg_lo ? (~w_eng_lo + 1'b1) : w_eng_lo;
      w_fix_hi = r_neg_hi ? (~w_eng_hi + 1'b1) : w_eng_hi;
    end else begin
      if (r_neg_lo) w_prod = ~w_prod + 1'b1;
      w_fix_lo = w_prod[M:0];
      w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
      w_fix_o  = r_signed ? (w_fix_hi != {WIDTH{w_fix_lo[M]}}) : (w_fix_hi != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_out1      <= '0;
      r_out2      <= '0;
      r_o         <= 1'b0;
      r_z         <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_signed    <= 1'b0;
      r_is_div    <= 1'b0;
      r_neg_lo    <= 1'b0;
      r_neg_hi    <= 1'b0;
    end else begin
      case (r_state)
        ITER: begin
          if (w_iter_last) begin
            r_state <= FIX;
            r_busy  <= 1'b0;
          end
        end
        FIX: begin
          r_out1      <= w_fix_lo;
          r_out2      <= w_fix_hi;
          r_o         <= w_fix_o;
          r_z         <= (w_fix_lo == '0);
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        default: begin
          if (w_accept) begin
            if (!is_muldiv(control)) begin
              r_out1      <= w_sc_res;
              r_out2      <= '0;
              r_o         <= w_sc_o;
              r_z         <= (w_sc_res == '0);
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else if (w_div0) begin
              r_out1      <= '1;
              r_out2      <= in1;
              r_o         <= 1'b1;
              r_z         <= 1'b0;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else if (w_divov) begin
              r_out1      <= MIN_NEG;
              r_out2      <= '0;
              r_o         <= 1'b1;
              r_z         <= 1'b0;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_out_valid <= 1'b0;
              r_busy      <= 1'b1;
              r_signed    <= control[1];
              r_is_div    <= control[0];
              r_neg_lo    <= w_sa ^ w_sb;
              r_neg_hi    <= control[0] ? w_sa : (w_sa ^ w_sb);
              r_state     <= ITER;
            end
          end else if (r_state == DONE && out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mc_alu.sv
// Directed-vector bench for mc_alu at WIDTH=32 plus key cases at WIDTH=8.
module tb_mc_alu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [3:0]  control = 4'h0;
  logic [31:0] in1 = '0, in2 = '0, out1, out2;
  logic        o, z, busy;
  state_t      dbg_state;

  logic        b8_in_valid = 1'b0, b8_in_ready, b8_out_valid, b8_out_ready = 1'b0;
  logic [3:0]  b8_control = 4'h0;
  logic [7:0]  b8_in1 = '0, b8_in2 = '0, b8_out1, b8_out2;
  logic        b8_o, b8_z, b8_busy;
  state_t      b8_dbg_state;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mc_alu #(.WIDTH(32)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .control(control), .in1(in1), .in2(in2), .out_valid(out_valid),
    .out_ready(out_ready), .out1(out1), .out2(out2), .o(o), .z(z),
    .busy(busy), .o_dbg_state(dbg_state)
  );

  mc_alu #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(b8_in_valid), .in_ready(b8_in_ready),
    .control(b8_control), .in1(b8_in1), .in2(b8_in2), .out_valid(b8_out_valid),
    .out_ready(b8_out_ready), .out1(b8_out1), .out2(b8_out2), .o(b8_o), .z(b8_z),
    .busy(b8_busy), .o_dbg_state(b8_dbg_state)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Issue one op, count edges from the accept edge until out_valid, then consume.
  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r1, output logic [31:0] r2,
                        output logic ro, output logic rz, output logic rbusy, output int lat);
    @(negedge clk);
    control = c; in1 = a; in2 = b; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; in1 = $urandom; in2 = $urandom; control = 4'($urandom_range(0, 15));
    lat = 1; rbusy = busy;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    r1 = out1; r2 = out2; ro = o; rz = z;
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic run_op8(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] r1, output logic [7:0] r2,
                         output logic ro, output int lat);
    @(negedge clk);
    b8_control = c; b8_in1 = a; b8_in2 = b; b8_in_valid = 1'b1; b8_out_ready = 1'b0;
    @(posedge clk); #1;
    b8_in_valid = 1'b0; b8_in1 = 8'($urandom); b8_in2 = 8'($urandom);
    lat = 1;
    while (!b8_out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    r1 = b8_out1; r2 = b8_out2; ro = b8_o;
    @(negedge clk); b8_out_ready = 1'b1;
    @(posedge clk); #1; b8_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if ({out1, out2} !== 64'h0) begin bad++; $display("FAIL reset_outs out1=%h out2=%h want 0", out1, out2); end
    total++; if ({o, z, out_valid, busy} !== 4'b0) begin bad++; $display("FAIL reset_flags o,z,v,busy=%b want 0000", {o, z, out_valid, busy}); end
    total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL reset_state got=%0d want IDLE", dbg_state); end
    @(negedge clk); rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want 1", in_ready); end
    total++; if (b8_in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready8 got=%b want 1", b8_in_ready); end
  endtask

  task automatic test_addsub();
    logic [31:0] r1, r2; logic ro, rz, rb; int lat;
    run_op(OP_ADDU, 32'h80000055, 32'h80000001, r1, r2, ro, rz, rb, lat);
    total++; if (r1 !== 32'h00000056) begin bad++; $display("FAIL addu_out1 got=%h want 00000056", r1); end
    total++; if ({ro, rz} !== 2'b10) begin bad++; $display("FAIL addu_flags o,z=%b want 10", {ro, rz}); end
    total++; if (lat !== 1) begin bad++; $display("FAIL addu_latency got=%0d want 1", lat); end
    run_op(OP_SUBU, 32'hF0FF0055, 32'hF0FF0055, r1, r2, ro, rz, rb, lat);
    total++; if ({r1, ro, rz} !== {32'h0, 2'b01}) begin bad++; $display("FAIL subu_eq got=%h o=%b z=%b want 0 o=0 z=1", r1, ro, rz); end
    run_op(OP_SUBU, 32'h00000001, 32'h00000055, r1, r2, ro, rz, rb, lat);
    total++; if ({r1, ro, rz} !== {32'hFFFFFFAC, 2'b10}) begin bad++; $display("FAIL subu_borrow got=%h o=%b z=%b want FFFFFFAC o=1 z=0", r1, ro, rz); end
  endtask

  typedef struct {
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e1;
    logic        eo;
  } vec_t;

  task automatic test_logic_ops();
    vec_t tbl[9];
    logic [31:0] r1, r2; logic ro, rz, rb; int lat;
    tbl[0] = '{OP_XOR,  32'hFF00FF00, 32'h0F0F0F0F, 32'hF00FF00F, 1'b0};
    tbl[1] = '{OP_NOR,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0};
    tbl[2] = '{OP_SLL,  32'h00000004, 32'h00000001, 32'h00000010, 1'b0};
    tbl[3] = '{OP_SRL,  32'h00000024, 32'h80000000, 32'h08000000, 1'b0};
    tbl[4] = '{OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0};
    tbl[5] = '{OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
    tbl[6] = '{OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1};
    tbl[7] = '{OP_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1};
    tbl[8] = '{OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
    for (int i = 0; i < 9; i++) begin
      run_op(tbl[i].c, tbl[i].a, tbl[i].b, r1, r2, ro, rz, rb, lat);
      total++;
      if ({r1, r2, ro, rz, lat[3:0]} !== {tbl[i].e1, 32'h0, tbl[i].eo, tbl[i].e1 == 32'h0, 4'd1}) begin
        bad++;
        $display("FAIL logic_vec%0d op=%h got out1=%h out2=%h o=%b z=%b lat=%0d want out1=%h out2=0 o=%b lat=1",
                 i, tbl[i].c, r1, r2, ro, rz, lat, tbl[i].e1, tbl[i].eo);
      end
    end
  endtask

  task automatic test_mul();
    logic [31:0] r1, r2; logic ro, rz, rb; int lat;
    run_op(OP_MULT, 32'hFFFFFFFE, 32'h00000003, r1, r2, ro, rz, rb, lat);
    total++; if ({r2, r1} !== 64'hFFFFFFFF_FFFFFFFA) begin bad++; $display("FAIL mult_neg got=%h_%h want FFFFFFFF_FFFFFFFA", r2, r1); end
    total++; if (ro !== 1'b0) begin bad++; $display("FAIL mult_neg_o got=%b want 0", ro); end
    total++; if (lat !== 34) begin bad++; $display("FAIL mult_latency got=%0d want 34", lat); end
    total++; if (rb !== 1'b1) begin bad++; $display("FAIL mult_busy got=%b want 1", rb); end
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, r1, r2, ro, rz, rb, lat);
    total++; if ({r2, r1, ro} !== {64'hFFFFFFFE_00000001, 1'b1}) begin bad++; $display("FAIL multu_max got=%h_%h o=%b want FFFFFFFE_00000001 o=1", r2, r1, ro); end
    run_op(OP_MULT, 32'h80000000, 32'h80000000, r1, r2, ro, rz, rb, lat);
    total++; if ({r2, r1, ro, rz} !== {64'h40000000_00000000, 2'b11}) begin bad++; $display("FAIL mult_minmin got=%h_%h o=%b z=%b want 40000000_00000000 o=1 z=1", r2, r1, ro, rz); end
  endtask

  task automatic test_div();
    logic [31:0] r1, r2; logic ro, rz, rb; int lat;
    run_op(OP_DIV, 32'hFFFFFFF9, 32'h00000002, r1, r2, ro, rz, rb, lat);
    total++; if ({r1, r2, ro} !== {32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0}) begin bad++; $display("FAIL div_neg got q=%h r=%h o=%b want FFFFFFFD FFFFFFFF o=0", r1, r2, ro); end
    total++; if (lat !== 34) begin bad++; $display("FAIL div_latency got=%0d want 34", lat); end
    run_op(OP_DIV, 32'h00000007, 32'hFFFFFFFE, r1, r2, ro, rz, rb, lat);
    total++; if ({r1, r2} !== {32'hFFFFFFFD, 32'h00000001}) begin bad++; $display("FAIL div_negdivisor got q=%h r=%h want FFFFFFFD 00000001", r1, r2); end
    run_op(OP_DIVU, 32'd100, 32'd7, r1, r2, ro, rz, rb, lat);
    total++; if ({r1, r2, ro} !== {32'd14, 32'd2, 1'b0}) begin bad++; $display("FAIL divu got q=%h r=%h o=%b want e 2 o=0", r1, r2, ro); end
    run_op(OP_DIVU, 32'd5, 32'd0, r1, r2, ro, rz, rb, lat);
    total++; if ({r1, r2, ro} !== {32'hFFFFFFFF, 32'd5, 1'b1}) begin bad++; $display("FAIL divu_zero got q=%h r=%h o=%b want FFFFFFFF 5 o=1", r1, r2, ro); end
    total++; if (lat !== 1) begin bad++; $display("FAIL divu_zero_latency got=%0d want 1", lat); end
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, r1, r2, ro, rz, rb, lat);
    total++; if ({r1, r2, ro, lat[7:0]} !== {32'h80000000, 32'h0, 1'b1, 8'd1}) begin bad++; $display("FAIL div_ovf got q=%h r=%h o=%b lat=%0d want 80000000 0 o=1 lat=1", r1, r2, ro, lat); end
  endtask

  task automatic test_hold_and_handoff();
    @(negedge clk);
    control = OP_AND; in1 = 32'h55555555; in2 = 32'h000000F0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    control = OP_OR; in1 = 32'h00000055; in2 = 32'h000000A0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({out_valid, out1, in_ready} !== {1'b1, 32'h00000050, 1'b0}) begin
        bad++; $display("FAIL hold_cycle%0d valid=%b out1=%h in_ready=%b want 1 00000050 0", i, out_valid, out1, in_ready);
      end
      @(posedge clk); #1;
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if ({out_valid, out1, o} !== {1'b1, 32'h000000F5, 1'b0}) begin bad++; $display("FAIL handoff_or valid=%b out1=%h o=%b want 1 000000F5 0", out_valid, out1, o); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL handoff_drain valid=%b want 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0]  c[4]  = '{OP_ADDU, OP_SLL, OP_SUBU, OP_OR};
    logic [31:0] a[4]  = '{32'd1, 32'd3, 32'd5, 32'h0000F000};
    logic [31:0] b[4]  = '{32'd2, 32'd1, 32'd5, 32'h0000000F};
    logic [31:0] e[4]  = '{32'd3, 32'd8, 32'd0, 32'h0000F00F};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      control = c[i]; in1 = a[i]; in2 = b[i]; in_valid = 1'b1;
      @(posedge clk); #1;
      total++;
      if ({out_valid, out1, z} !== {1'b1, e[i], e[i] == 32'h0}) begin
        bad++; $display("FAIL b2b_op%0d valid=%b out1=%h z=%b want 1 %h", i, out_valid, out1, z, e[i]);
      end
    end
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain valid=%b want 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_rst_mid_iter();
    logic [31:0] r1, r2; logic ro, rz, rb; int lat;
    @(negedge clk);
    control = OP_MULTU; in1 = 32'h12345678; in2 = 32'h9ABCDEF0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    total++; if ({busy, out_valid} !== 2'b10) begin bad++; $display("FAIL iter10_busy busy,valid=%b want 10", {busy, out_valid}); end
    rst = 1'b1;
    #1;
    total++; if ({out1, out2, o, z, out_valid, busy} !== 68'h0) begin bad++; $display("FAIL rst_mid_iter out1=%h out2=%h o,z,v,busy=%b want 0", out1, out2, {o, z, out_valid, busy}); end
    total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL rst_mid_iter_state got=%0d want IDLE", dbg_state); end
    @(negedge clk); rst = 1'b0;
    run_op(OP_ADDU, 32'd2, 32'd3, r1, r2, ro, rz, rb, lat);
    total++; if ({r1, ro, lat[3:0]} !== {32'd5, 1'b0, 4'd1}) begin bad++; $display("FAIL post_rst_addu got=%h o=%b lat=%0d want 5 o=0 lat=1", r1, ro, lat); end
    run_op(OP_MULTU, 32'd1000, 32'd1000, r1, r2, ro, rz, rb, lat);
    total++; if ({r2, r1, ro} !== {64'd1000000, 1'b0}) begin bad++; $display("FAIL post_rst_multu got=%h_%h o=%b want 0_000f4240 o=0", r2, r1, ro); end
  endtask

  task automatic test_width8();
    logic [7:0] r1, r2; logic ro; int lat;
    run_op8(OP_ADDU, 8'h85, 8'h81, r1, r2, ro, lat);
    total++; if ({r1, r2, ro, lat[3:0]} !== {8'h06, 8'h00, 1'b1, 4'd1}) begin bad++; $display("FAIL w8_addu got=%h %h o=%b lat=%0d want 06 00 o=1 lat=1", r1, r2, ro, lat); end
    run_op8(OP_MULT, 8'hFE, 8'h03, r1, r2, ro, lat);
    total++; if ({r2, r1, ro} !== {16'hFFFA, 1'b0}) begin bad++; $display("FAIL w8_mult got=%h_%h o=%b want FFFA o=0", r2, r1, ro); end
    total++; if (lat !== 10) begin bad++; $display("FAIL w8_mult_latency got=%0d want 10", lat); end
    run_op8(OP_DIV, 8'hF9, 8'h02, r1, r2, ro, lat);
    total++; if ({r1, r2, ro} !== {8'hFD, 8'hFF, 1'b0}) begin bad++; $display("FAIL w8_div got q=%h r=%h o=%b want FD FF o=0", r1, r2, ro); end
    run_op8(OP_DIVU, 8'h05, 8'h00, r1, r2, ro, lat);
    total++; if ({r1, r2, ro, lat[3:0]} !== {8'hFF, 8'h05, 1'b1, 4'd1}) begin bad++; $display("FAIL w8_divu_zero got q=%h r=%h o=%b lat=%0d want FF 05 o=1 lat=1", r1, r2, ro, lat); end
    run_op8(OP_SLL, 8'h0B, 8'h01, r1, r2, ro, lat);
    total++; if (r1 !== 8'h08) begin bad++; $display("FAIL w8_sll_shamt got=%h want 08", r1); end
  endtask

  initial begin
    test_reset();
    test_addsub();
    test_logic_ops();
    test_mul();
    test_div();
    test_hold_and_handoff();
    test_back_to_back();
    test_rst_mid_iter();
    test_width8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
